// File: rtl/soc_onchip_mem.sv
// Dual-port Avalon-MM on-chip RAM: byte-lane writes, RD_LAT-cycle reads, s1-wins write collisions.
// Optional zero fill of the whole array after reset: define ONCHIP_MEM_ZERO_INIT_EN.
module soc_onchip_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 25000,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest,
  output logic              init_done
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {INIT, READY} state_t;
  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic waitrequest;

  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][NB-1:0]     be;
  logic [1:0][DATA_W-1:0] wdata, rd_word, rdata;
  logic [1:0][IW-1:0]     idx;
  logic [1:0]             cs, rd, wr, acc, wr_acc, rd_acc, in_rng, rvalid;

  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};

  assign waitrequest    = reset_req | ~init_done;
  assign s1_waitrequest = waitrequest;
  assign s2_waitrequest = waitrequest;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0] dq;

    assign acc[p]     = cs[p] & (rd[p] | wr[p]) & clken & ~waitrequest;
    assign wr_acc[p]  = acc[p] & wr[p];
    assign rd_acc[p]  = acc[p] & rd[p] & ~wr[p];
    assign in_rng[p]  = {1'b0, addr[p]} < LIMIT;
    assign idx[p]     = addr[p][IW-1:0];
    // Array is sampled before this edge's writes land, so read-during-write sees old data
    assign rd_word[p] = in_rng[p] ? mem[idx[p]] : '0;

    // Data stages load only behind a valid, so readdata keeps the last delivered word
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_pipe <= '0;
        dq       <= '0;
      end else if (clken) begin
        vld_pipe[1] <= rd_acc[p];
        if (rd_acc[p]) dq[1] <= rd_word[p];
        for (int s = 2; s <= RD_LAT; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          if (vld_pipe[s-1]) dq[s] <= dq[s-1];
        end
      end
    end

    assign rvalid[p] = vld_pipe[RD_LAT] & clken;
    assign rdata[p]  = dq[RD_LAT];
  end

  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdatavalid = rvalid[1];

`ifdef ONCHIP_MEM_ZERO_INIT_EN
  logic [ADDR_W-1:0] init_addr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      init_done <= 1'b0;
`ifdef ONCHIP_MEM_ZERO_INIT_EN
      init_addr <= '0;
`endif
    end else if (clken) begin
      case (state)
        INIT: begin
`ifdef ONCHIP_MEM_ZERO_INIT_EN
          init_addr <= init_addr + 1'b1;
          if (init_addr == ADDR_W'(DEPTH - 1)) begin
            state     <= READY;
            init_done <= 1'b1;
          end
`else
          state     <= READY;
          init_done <= 1'b1;
`endif
        end
        default: begin
          state     <= READY;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // s2 goes first and is skipped outright on an address clash, so s1 owns the whole word
  always_ff @(posedge clk) begin
`ifdef ONCHIP_MEM_ZERO_INIT_EN
    if (clken && state == INIT) mem[init_addr[IW-1:0]] <= '0;
`endif
    if (wr_acc[1] && in_rng[1] && !(wr_acc[0] && addr[0] == addr[1])) begin
      for (int b = 0; b < NB; b++)
        if (be[1][b]) mem[idx[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
    end
    if (wr_acc[0] && in_rng[0]) begin
      for (int b = 0; b < NB; b++)
        if (be[0][b]) mem[idx[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_soc_onchip_mem.sv
// Randomized + directed bench for soc_onchip_mem against a queue-based transaction model.
module tb_soc_onchip_mem;
  localparam int DW = 32, AW = 5, DEPTH = 16, RD_LAT = 2;
`ifdef ONCHIP_MEM_ZERO_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif

  logic clk = 1'b0, reset_n = 1'b0, clken = 1'b1, reset_req = 1'b0;
  logic [1:0] cs, rd, wr, rvalid, wreq;
  logic [1:0][AW-1:0] addr;
  logic [1:0][3:0] be;
  logic [1:0][DW-1:0] wd, rdata;
  logic init_done;

  soc_onchip_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1_address(addr[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]),
    .s1_write(wr[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[0]),
    .s1_readdatavalid(rvalid[0]), .s1_waitrequest(wreq[0]),
    .s2_address(addr[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]),
    .s2_write(wr[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[1]),
    .s2_readdatavalid(rvalid[1]), .s2_waitrequest(wreq[1]),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic known; int due; } rd_t;
  rd_t pq[2][$];
  logic [DW-1:0] mmem [DEPTH];
  logic [3:0] mk [DEPTH];
  logic [DW-1:0] last [2];
  logic [DW-1:0] got [2];
  logic last_k [2];
  int dcnt [2];
  int en_cnt, n_chk, n_err, d0, d1;
  logic exp_wait;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic ready();
    return en_cnt >= INIT_CYC;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pq[p].delete();
      last[p] = '0;
      last_k[p] = 1'b1;
    end
    en_cnt = 0;
`ifdef ONCHIP_MEM_ZERO_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i] = '0;
      mk[i] = 4'hF;
    end
`endif
  endtask

  task automatic wr_model(input int p);
    int a;
    a = int'(addr[p]);
    for (int b = 0; b < 4; b++)
      if (be[p][b]) begin
        mmem[a][b*8 +: 8] = wd[p][b*8 +: 8];
        mk[a][b] = 1'b1;
      end
  endtask

  // One clock: check outputs mid-low-phase, then advance the model at the rising edge
  task automatic cyc();
    bit due;
    int a;
    rd_t e;
    logic [1:0] acc;
    #1;
    exp_wait = reset_req | ~ready();
    chk("init_done", init_done, ready());
    for (int p = 0; p < 2; p++) begin
      due = pq[p].size() > 0 && pq[p][0].due == en_cnt;
      chk($sformatf("wait%0d", p + 1), wreq[p], exp_wait);
      chk($sformatf("rvalid%0d", p + 1), rvalid[p], due & clken);
      if (due) begin
        if (pq[p][0].known) chk($sformatf("rdata%0d", p + 1), rdata[p], pq[p][0].d);
      end else if (last_k[p]) chk($sformatf("rhold%0d", p + 1), rdata[p], last[p]);
      if (rvalid[p]) begin
        got[p] = rdata[p];
        dcnt[p]++;
      end
    end
    @(posedge clk);
    if (reset_n && clken) begin
      for (int p = 0; p < 2; p++) begin
        if (pq[p].size() > 0 && pq[p][0].due == en_cnt) begin
          last[p] = pq[p][0].d;
          last_k[p] = pq[p][0].known;
          void'(pq[p].pop_front());
        end
        acc[p] = cs[p] & (rd[p] | wr[p]) & ~exp_wait;
        if (acc[p] & rd[p] & ~wr[p]) begin
          a = int'(addr[p]);
          e.d = (a < DEPTH) ? mmem[a] : '0;
          e.known = (a < DEPTH) ? &mk[a] : 1'b1;
          e.due = en_cnt + RD_LAT;
          pq[p].push_back(e);
        end
      end
      if (acc[1] & wr[1] && int'(addr[1]) < DEPTH && !(acc[0] & wr[0] && addr[0] == addr[1]))
        wr_model(1);
      if (acc[0] & wr[0] && int'(addr[0]) < DEPTH) wr_model(0);
      en_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cs = '0; rd = '0; wr = '0;
  endtask

  task automatic put(input int p, input bit w, input bit r, input int a,
                     input logic [3:0] b, input logic [DW-1:0] d);
    cs[p] = 1'b1; wr[p] = w; rd[p] = r; addr[p] = AW'(a); be[p] = b; wd[p] = d;
  endtask

  // Asserts reset between edges and checks the outputs react with no clock
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wait1", wreq[0], 1'b1);
    chk("rst_wait2", wreq[1], 1'b1);
    chk("rst_idone", init_done, 1'b0);
    chk("rst_rv1", rvalid[0], 1'b0);
    chk("rst_rv2", rvalid[1], 1'b0);
    chk("rst_rd1", rdata[0], '0);
    chk("rst_rd2", rdata[1], '0);
    model_reset();
    @(negedge clk);
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; dcnt[0] = 0; dcnt[1] = 0;
    got[0] = '0; got[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mk[i] = 4'h0; end
    idle(); addr = '0; be = '0; wd = '0;
    model_reset();
    do_reset();
    repeat (INIT_CYC + 2) cyc();
`ifdef ONCHIP_MEM_ZERO_INIT_EN
    for (int a = 0; a < DEPTH; a++) begin put(0, 0, 1, a, 4'h0, '0); cyc(); end
    idle(); repeat (3) cyc();
`endif
    // byte-lane merge
    put(0, 1, 0, 3, 4'hF, 32'hDEADBEEF); cyc();
    put(0, 1, 0, 3, 4'h1, 32'h000000AA); cyc();
    put(0, 0, 1, 3, 4'h0, '0); cyc();
    idle(); got[0] = '0; repeat (3) cyc();
    chk("merge", got[0], 32'hDEADBEAA);
    // dual write collision
    put(0, 1, 0, 5, 4'hF, 32'h11111111); put(1, 1, 0, 5, 4'hF, 32'h22222222); cyc();
    idle(); put(0, 0, 1, 5, 4'h0, '0); cyc();
    idle(); got[0] = '0; repeat (3) cyc();
    chk("collide", got[0], 32'h11111111);
    // cross-port read-during-write
    put(0, 1, 0, 7, 4'hF, '0); cyc();
    put(0, 1, 0, 7, 4'hF, 32'h5); put(1, 0, 1, 7, 4'h0, '0); cyc();
    idle(); put(1, 0, 1, 7, 4'h0, '0); cyc();
    idle(); got[1] = '1; cyc();
    chk("rdw_old", got[1], '0);
    cyc();
    chk("rdw_new", got[1], 32'h5);
    // clken stall mid-latency
    put(0, 0, 1, 3, 4'h0, '0); cyc();
    idle(); d0 = dcnt[0]; clken = 1'b0; repeat (3) cyc();
    clken = 1'b1; repeat (3) cyc();
    chk("stall_once", dcnt[0] - d0, 1);
    // out-of-range read
    put(1, 0, 1, 20, 4'h0, '0); cyc();
    idle(); got[1] = '1; d1 = dcnt[1]; repeat (3) cyc();
    chk("oor_data", got[1], '0);
    chk("oor_valid", dcnt[1] - d1, 1);
    // reset_req blocks new commands, in-flight read completes
    put(0, 0, 1, 3, 4'h0, '0); cyc();
    reset_req = 1'b1; put(0, 0, 1, 5, 4'h0, '0); d0 = dcnt[0]; repeat (3) cyc();
    reset_req = 1'b0; idle(); cyc();
    chk("rreq_inflight", dcnt[0] - d0, 1);
    // reset with a read in flight
    put(0, 0, 1, 3, 4'h0, '0); cyc();
    idle(); d0 = dcnt[0]; do_reset();
    repeat (INIT_CYC + 4) cyc();
    chk("rst_drop", dcnt[0] - d0, 0);
    // random traffic
    for (int a = 0; a < DEPTH; a++) begin put(0, 1, 0, a, 4'hF, DW'($urandom)); cyc(); end
    idle();
    repeat (600) begin
      clken = $urandom_range(0, 9) != 0;
      reset_req = $urandom_range(0, 9) == 0;
      for (int p = 0; p < 2; p++) begin
        put(p, 1'($urandom), 1'($urandom), $urandom_range(0, 19), 4'($urandom), DW'($urandom));
        cs[p] = $urandom_range(0, 3) != 0;
      end
      cyc();
    end
    idle(); clken = 1'b1; reset_req = 1'b0;
    repeat (4) cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
